// File: rtl/unidade_mult_div.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : unidade_mult_div                                               |
// | Purpose : Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO regs     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module unidade_mult_div #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [1:0]         operacao,
  input  logic [LARGURA-1:0] operandoA,
  input  logic [LARGURA-1:0] operandoB,
  input  logic               escreveHi,
  input  logic               escreveLo,
  input  logic [LARGURA-1:0] dadoEscrita,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    AJUSTE  = 2'd2
  } estado_t;

  localparam int cLarguraCont = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [cLarguraCont-1:0] cUltimaIter = cLarguraCont'(LARGURA - 1);

  estado_t                 rEstado;
  estado_t                 wProxEstado;
  logic [cLarguraCont-1:0] rContador;
  logic                    rEhDivisao;
  logic                    rSinalRes;
  logic                    rSinalResto;
  logic                    rDivZero;
  logic [LARGURA-1:0]      rOperando;
  logic [LARGURA-1:0]      rAccHi;
  logic [LARGURA-1:0]      rAccLo;

  logic                    wNegA;
  logic                    wNegB;
  logic [LARGURA-1:0]      wMagA;
  logic [LARGURA-1:0]      wMagB;
  logic [LARGURA:0]        wSoma;
  logic [LARGURA:0]        wTentativa;
  logic [LARGURA:0]        wDiferenca;
  logic [2*LARGURA-1:0]    wProduto;
  logic [2*LARGURA-1:0]    wProdutoFinal;
  logic [LARGURA-1:0]      wQuociente;
  logic [LARGURA-1:0]      wResto;

  // Signed ops work on magnitudes; the signs are re-applied in AJUSTE.
  assign wNegA = operacao[0] & operandoA[LARGURA-1];
  assign wNegB = operacao[0] & operandoB[LARGURA-1];
  assign wMagA = wNegA ? -operandoA : operandoA;
  assign wMagB = wNegB ? -operandoB : operandoB;

  // Multiply step: keep the carry so the right shift does not lose it.
  assign wSoma = {1'b0, rAccHi} + ({1'b0, rOperando} & {(LARGURA+1){rAccLo[0]}});

  // Restoring divide step; a zero divisor never goes negative, which yields
  // an all-ones quotient and the dividend shifted into the remainder.
  assign wTentativa = {rAccHi, rAccLo[LARGURA-1]};
  assign wDiferenca = wTentativa - {1'b0, rOperando};

  assign wProduto      = {rAccHi, rAccLo};
  assign wProdutoFinal = rSinalRes ? -wProduto : wProduto;
  assign wQuociente    = rDivZero ? '1 : (rSinalRes ? -rAccLo : rAccLo);
  assign wResto        = rSinalResto ? -rAccHi : rAccHi;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rEstado <= OCIOSO;
    else        rEstado <= wProxEstado;
  end

  always_comb begin
    wProxEstado = rEstado;
    case (rEstado)
      OCIOSO:  if (inicio) wProxEstado = CALCULA;
      CALCULA: if (rContador == cUltimaIter) wProxEstado = AJUSTE;
      AJUSTE:  wProxEstado = OCIOSO;
      default: wProxEstado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rContador   <= '0;
      rEhDivisao  <= 1'b0;
      rSinalRes   <= 1'b0;
      rSinalResto <= 1'b0;
      rDivZero    <= 1'b0;
      rOperando   <= '0;
      rAccHi      <= '0;
      rAccLo      <= '0;
      hi          <= '0;
      lo          <= '0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (rEstado)
        OCIOSO: begin
          if (inicio) begin
            rContador   <= '0;
            rEhDivisao  <= operacao[1];
            rSinalRes   <= wNegA ^ wNegB;
            rSinalResto <= wNegA;
            rDivZero    <= operacao[1] & (operandoB == '0);
            rOperando   <= operacao[1] ? wMagB : wMagA;
            rAccHi      <= '0;
            rAccLo      <= operacao[1] ? wMagA : wMagB;
            ocupado     <= 1'b1;
          end else begin
            if (escreveHi) hi <= dadoEscrita;
            if (escreveLo) lo <= dadoEscrita;
          end
        end
        CALCULA: begin
          rContador <= rContador + 1'b1;
          if (rEhDivisao) begin
            rAccHi <= wDiferenca[LARGURA] ? wTentativa[LARGURA-1:0]
                                          : wDiferenca[LARGURA-1:0];
            rAccLo <= {rAccLo[LARGURA-2:0], ~wDiferenca[LARGURA]};
          end else begin
            rAccHi <= wSoma[LARGURA:1];
            rAccLo <= {wSoma[0], rAccLo[LARGURA-1:1]};
          end
        end
        AJUSTE: begin
          if (rEhDivisao) begin
            hi <= wResto;
            lo <= wQuociente;
          end else begin
            hi <= wProdutoFinal[2*LARGURA-1:LARGURA];
            lo <= wProdutoFinal[LARGURA-1:0];
          end
          pronto  <= 1'b1;
          ocupado <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
